// File: rtl/e_mdu.sv
// Multiply/divide unit for the E stage. A start computes the result into
// temporaries at once; HI/LO are committed after a fixed busy window.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  E_MDUOp,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] E_MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] thi_q, thi_d, tlo_q, tlo_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               b_zero, div_ovf;
  logic        [31:0] b_safe;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'h0, A} * {32'h0, B};

  // Divisor is forced nonzero so the dividers never see 0; the B=0 result is discarded anyway.
  assign b_zero  = (B == 32'h0);
  assign b_safe  = b_zero ? 32'h1 : B;
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign quo_s   = div_ovf ? 32'sh8000_0000 : $signed(A) / $signed(b_safe);
  assign rem_s   = div_ovf ? 32'sh0 : $signed(A) % $signed(b_safe);
  assign quo_u   = A / b_safe;
  assign rem_u   = A % b_safe;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    case (state_q)
      S_IDLE: begin
        if (!Req) begin
          case (E_MDUOp)
            OP_MULT: begin
              thi_d = prod_s[63:32];
              tlo_d = prod_s[31:0];
              cnt_d = MULT_CNT;
              state_d = S_RUN;
            end
            OP_MULTU: begin
              thi_d = prod_u[63:32];
              tlo_d = prod_u[31:0];
              cnt_d = MULT_CNT;
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero re-commits the current HI/LO, leaving them unchanged.
              if (b_zero) begin
                thi_d = hi_q;
                tlo_d = lo_q;
              end else if (E_MDUOp == OP_DIV) begin
                thi_d = rem_s;
                tlo_d = quo_s;
              end else begin
                thi_d = rem_u;
                tlo_d = quo_u;
              end
              cnt_d = DIV_CNT;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          hi_d    = thi_q;
          lo_d    = tlo_q;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      thi_q   <= 32'h0;
      tlo_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
    end
  end

  always_comb begin
    E_MDUOut = 32'h0;
    if (E_MDUOp == OP_MFHI) E_MDUOut = hi_q;
    else if (E_MDUOp == OP_MFLO) E_MDUOut = lo_q;
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: table of back-to-back ops, flush/reset corner sequences
// and random unsigned multiply/divide against an arithmetic model.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  E_MDUOp;
  logic        Req;
  logic        Busy;
  logic [31:0] E_MDUOut, HI, LO;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model_hilo;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .E_MDUOp  (E_MDUOp),
    .Req      (Req),
    .Busy     (Busy),
    .E_MDUOut (E_MDUOut),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    int          n;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a later falling edge,
  // so chained calls present the next op with no idle cycle in between.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, input int n, input logic [63:0] exp,
                        input int flush_at, input int reset_at);
    logic [63:0] got;
    int          cnt;
    logic        hold_ok;
    E_MDUOp = op; A = a; B = b; Req = req;
    exp_q.push_back(exp);
    @(negedge clk);
    E_MDUOp = 4'd0; Req = 1'b0; A = 32'h0; B = 32'h0;
    cnt = 0;
    hold_ok = 1'b1;
    while (Busy === 1'b1 && cnt < 40) begin
      cnt++;
      if ({HI, LO} !== model_hilo) hold_ok = 1'b0;
      Req   = (cnt == flush_at);
      reset = (cnt == reset_at);
      @(negedge clk);
    end
    Req = 1'b0;
    reset = 1'b0;
    check("busy_cycles", 64'(cnt), 64'(n));
    check("hold_while_busy", {63'h0, hold_ok}, 64'h1);
    got = exp_q.pop_front();
    check("hilo", {HI, LO}, got);
    model_hilo = got;
    E_MDUOp = 4'd5; #1;
    check("mfhi", {32'h0, E_MDUOut}, {32'h0, got[63:32]});
    E_MDUOp = 4'd6; #1;
    check("mflo", {32'h0, E_MDUOut}, {32'h0, got[31:0]});
    E_MDUOp = 4'd0; #1;
    check("out_none", {32'h0, E_MDUOut}, 64'h0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rexp;
    logic        stay_ok;

    vecs[0]  = '{4'd1, 32'hFFFF_FFFE, 32'd3,         1'b0, 5,  64'hFFFF_FFFF_FFFF_FFFA};
    vecs[1]  = '{4'd2, 32'hFFFF_FFFF, 32'd2,         1'b0, 5,  64'h0000_0001_FFFF_FFFE};
    vecs[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,         1'b0, 10, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3]  = '{4'd7, 32'h11,        32'h0,         1'b0, 0,  64'h0000_0011_FFFF_FFFD};
    vecs[4]  = '{4'd8, 32'h22,        32'h0,         1'b0, 0,  64'h0000_0011_0000_0022};
    vecs[5]  = '{4'd4, 32'h1234,      32'h0,         1'b0, 10, 64'h0000_0011_0000_0022};
    vecs[6]  = '{4'd8, 32'h5A,        32'h0,         1'b0, 0,  64'h0000_0011_0000_005A};
    vecs[7]  = '{4'd1, 32'd5,         32'd7,         1'b1, 0,  64'h0000_0011_0000_005A};
    vecs[8]  = '{4'd7, 32'h99,        32'h0,         1'b1, 0,  64'h0000_0011_0000_005A};
    vecs[9]  = '{4'd4, 32'd100,       32'd7,         1'b0, 10, 64'h0000_0002_0000_000E};
    vecs[10] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 1'b0, 10, 64'h0000_0001_FFFF_FFFD};
    vecs[11] = '{4'd2, 32'h0001_0000, 32'h0001_0000, 1'b0, 5,  64'h0000_0001_0000_0000};
    vecs[12] = '{4'd9, 32'd1,         32'd1,         1'b0, 0,  64'h0000_0001_0000_0000};
    vecs[13] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 5,  64'h4000_0000_0000_0000};

    reset = 1'b1; A = 32'h0; B = 32'h0; E_MDUOp = 4'd0; Req = 1'b0;
    model_hilo = 64'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {63'h0, Busy}, 64'h0);
    check("reset_hilo", {HI, LO}, 64'h0);

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].req, vecs[i].n, vecs[i].exp, 0, 0);

    // Flush request on busy cycle 2 must not abort the divide: -9/4 = -2 rem -1.
    run_op(4'd3, 32'hFFFF_FFF7, 32'd4, 1'b0, 10, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0);

    // Reset on busy cycle 3 of a multiply: discarded, registers cleared.
    run_op(4'd1, 32'd3, 32'd4, 1'b0, 3, 64'h0, 0, 3);
    stay_ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (Busy !== 1'b0 || {HI, LO} !== 64'h0) stay_ok = 1'b0;
    end
    check("no_commit_after_reset", {63'h0, stay_ok}, 64'h1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      if (i % 2 == 0) begin
        rb = $urandom;
        rexp = {32'h0, ra} * {32'h0, rb};
        run_op(4'd2, ra, rb, 1'b0, 5, rexp, 0, 0);
      end else begin
        rb = $urandom_range(1, 1000);
        rexp = {ra % rb, ra / rb};
        run_op(4'd4, ra, rb, 1'b0, 10, rexp, 0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
